// File: rtl/sram_port_arbiter_pkg.sv
// sram_arb_pkg: shared types and default sizing for the SRAM port arbiter.
//   arb_state_e  : lock FSM state encoding (ARB / LOCKED)
//   DEF_*        : default parameter values for the top level
//   CNT_W        : lock counter width, wide enough for LOCK_MAX up to 255
package sram_arb_pkg;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_DEPTH    = 4096;
  localparam int DEF_NREQ     = 2;
  localparam int DEF_LOCK_MAX = 16;
  localparam int CNT_W        = 8;

endpackage

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req [NREQ] : request vector
//   ptr [IW]   : index of the last winner; search starts just after it
//   gnt [NREQ] : one-hot grant (zero when nothing requests)
//   idx [IW]   : index of the granted requester (0 when nothing requests)
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // Offsets 1..NREQ walk every index once, ending on ptr itself so a
    // lone requester that just won is picked again.
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    if (found) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM macro between NREQ
// requesters, one access per cycle, round-robin with a bounded bus lock.
//   hclk, hreset           : clock, synchronous active-high reset
//   req/we/lock [NREQ]     : per-requester request, write flag, lock hold
//   addr  [NREQ*WIDTH_ADDR]: word address, requester i in slice i
//   wdata [NREQ*WIDTH]     : write data, requester i in slice i
//   gnt    [NREQ]          : zero-cycle grant, one-hot or zero
//   rvalid [NREQ], rdata   : read return, one cycle after acceptance
//   lock_abort             : one-cycle pulse on a forced lock release
//   sram_csn/wen/a/d, sram_q : SRAM macro pins
//
// state  | meaning
// -------+--------------------------------------------------------------
// ARB    | round-robin among all requesters, search starts after ptr
// LOCKED | owner has exclusive access; others wait until release/abort
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int WIDTH_ADDR = $clog2(DEPTH),
  parameter int NREQ       = DEF_NREQ,
  parameter int LOCK_MAX   = DEF_LOCK_MAX
) (
  input  logic                       hclk,
  input  logic                       hreset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            we,
  input  logic [NREQ-1:0]            lock,
  input  logic [NREQ*WIDTH_ADDR-1:0] addr,
  input  logic [NREQ*WIDTH-1:0]      wdata,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            rvalid,
  output logic [WIDTH-1:0]           rdata,
  output logic                       lock_abort,
  output logic                       sram_csn,
  output logic                       sram_wen,
  output logic [WIDTH_ADDR-1:0]      sram_a,
  output logic [WIDTH-1:0]           sram_d,
  input  logic [WIDTH-1:0]           sram_q
);

  localparam int IW = $clog2(NREQ);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  arb_state_e       state, state_nxt;
  logic [IW-1:0]    ptr, ptr_nxt;
  logic [IW-1:0]    owner, owner_nxt;
  logic [CNT_W-1:0] lock_cnt, cnt_nxt, cnt_inc;
  logic             lock_abort_q, abort_nxt;
  logic [NREQ-1:0]  rd_pend, rd_pend_nxt;

  logic [NREQ-1:0]  arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic [NREQ-1:0]  owner_oh;
  logic [IW-1:0]    sel;
  logic             acc;
  logic             others;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state        <= ST_ARB;
      ptr          <= IW'(NREQ - 1);
      owner        <= '0;
      lock_cnt     <= '0;
      lock_abort_q <= 1'b0;
      rd_pend      <= '0;
    end else begin
      state        <= state_nxt;
      ptr          <= ptr_nxt;
      owner        <= owner_nxt;
      lock_cnt     <= cnt_nxt;
      lock_abort_q <= abort_nxt;
      rd_pend      <= rd_pend_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    owner_nxt   = owner;
    cnt_nxt     = lock_cnt;
    abort_nxt   = 1'b0;
    rd_pend_nxt = (acc && !we[sel]) ? gnt : '0;
    others      = |(req & ~owner_oh);
    cnt_inc     = (lock_cnt == CNT_MAX) ? lock_cnt : lock_cnt + CNT_W'(1);
    if (acc) ptr_nxt = sel;
    case (state)
      ST_ARB: begin
        if (acc && lock[sel]) begin
          state_nxt = ST_LOCKED;
          owner_nxt = sel;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ST_LOCKED: begin
        if ((acc && !lock[owner]) || (!req[owner] && !lock[owner])) begin
          state_nxt = ST_ARB;
          cnt_nxt   = '0;
        end else begin
          if (acc) cnt_nxt = cnt_inc;
          // The current owner access still goes through; the release lands
          // next cycle with ptr parked on the owner so it ranks last.
          if (cnt_nxt == CNT_MAX && others) begin
            state_nxt = ST_ARB;
            cnt_nxt   = '0;
            abort_nxt = 1'b1;
            ptr_nxt   = owner;
          end
        end
      end
      default: state_nxt = ST_ARB;
    endcase
  end

  // Grant and SRAM pins are forced idle while hreset is high so the
  // reset cycle itself shows reset values on every output.
  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
    gnt             = '0;
    sel             = arb_idx;
    if (!hreset) begin
      if (state == ST_LOCKED) begin
        gnt = req & owner_oh;
        sel = owner;
      end else begin
        gnt = arb_gnt;
      end
    end
    acc        = |gnt;
    sram_csn   = ~acc;
    sram_wen   = ~(acc & we[sel]);
    sram_a     = acc ? addr[sel*WIDTH_ADDR +: WIDTH_ADDR] : '0;
    sram_d     = acc ? wdata[sel*WIDTH +: WIDTH] : '0;
    rvalid     = hreset ? '0 : rd_pend;
    rdata      = (|rvalid) ? sram_q : '0;
    lock_abort = lock_abort_q & ~hreset;
  end

endmodule
